// File: rtl/datamem_responder_if.sv
// Load/store request and response channel between the MEM stage and the data memory.
// The master is the pipeline side; the slave is the memory responder.
interface datamem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [3:0]  req_xfer_size;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_xfer_size, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_xfer_size, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/datamem_responder.sv
// Byte-addressed data memory with a programmable number of wait states.
// It handles one outstanding load/store and returns data or an error over a valid/ready response.
module datamem_responder #(
  parameter int DEPTH_BYTES = 64,
  parameter int WAIT_CYCLES = 2
) (
  input logic               clk,
  input logic               reset,
  datamem_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH_BYTES);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t        state;
  logic [3:0]    wait_cnt;
  logic          lat_write;
  logic [63:0]   lat_addr;
  logic [63:0]   lat_wdata;
  logic [3:0]    lat_size;
  logic [7:0]    mem [DEPTH_BYTES];
  logic          req_ready_q;
  logic          resp_valid_q;
  logic [63:0]   resp_rdata_q;
  logic          resp_err_q;

  logic          accept;
  logic          go_resp;
  logic          acc_write;
  logic [63:0]   acc_addr;
  logic [63:0]   acc_wdata;
  logic [3:0]    acc_size;
  logic          size_ok;
  logic          align_ok;
  logic          range_ok;
  logic          acc_err;
  logic [64:0]   end_addr;
  logic [AW-1:0] base;
  logic [63:0]   acc_rdata;

  assign accept  = bus.req_valid && req_ready_q && (state == ST_IDLE);
  assign go_resp = (accept && (WAIT_CYCLES == 0)) || ((state == ST_WAIT) && (wait_cnt == 4'd0));

  // With zero wait states the access happens on the accepting edge, so it must see the live request.
  assign acc_write = (state == ST_IDLE) ? bus.req_write     : lat_write;
  assign acc_addr  = (state == ST_IDLE) ? bus.req_addr      : lat_addr;
  assign acc_wdata = (state == ST_IDLE) ? bus.req_wdata     : lat_wdata;
  assign acc_size  = (state == ST_IDLE) ? bus.req_xfer_size : lat_size;

  always_comb begin
    size_ok   = (acc_size == 4'd1) || (acc_size == 4'd2) || (acc_size == 4'd4) || (acc_size == 4'd8);
    align_ok  = (acc_addr & (64'(acc_size) - 64'd1)) == 64'd0;
    end_addr  = {1'b0, acc_addr} + 65'(acc_size);
    range_ok  = end_addr <= 65'(DEPTH_BYTES);
    acc_err   = !(size_ok && align_ok && range_ok);
    base      = acc_addr[AW-1:0];
    acc_rdata = '0;
    for (int k = 0; k < 8; k++) begin
      if (!acc_err && !acc_write && (4'(k) < acc_size)) begin
        acc_rdata[8*k +: 8] = mem[base + AW'(k)];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      wait_cnt     <= '0;
      lat_write    <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      lat_size     <= '0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      for (int i = 0; i < DEPTH_BYTES; i++) begin
        mem[i] <= 8'h00;
      end
    end else begin
      if (go_resp) begin
        resp_valid_q <= 1'b1;
        resp_rdata_q <= acc_rdata;
        resp_err_q   <= acc_err;
        if (acc_write && !acc_err) begin
          for (int k = 0; k < 8; k++) begin
            if (4'(k) < acc_size) begin
              mem[base + AW'(k)] <= acc_wdata[8*k +: 8];
            end
          end
        end
      end
      case (state)
        ST_IDLE: begin
          req_ready_q <= 1'b1;
          if (accept) begin
            lat_write   <= bus.req_write;
            lat_addr    <= bus.req_addr;
            lat_wdata   <= bus.req_wdata;
            lat_size    <= bus.req_xfer_size;
            req_ready_q <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              state <= ST_RESP;
            end else begin
              state    <= ST_WAIT;
              wait_cnt <= 4'(WAIT_CYCLES - 1);
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (bus.resp_ready) begin
            state        <= ST_IDLE;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            req_ready_q  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_datamem_responder.sv
// Directed bench for datamem_responder: three instances with 2, 0 and 15 wait states.
// Expected values are hand-computed constants.
module tb_datamem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  sel;
  logic        req_valid;
  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [3:0]  req_size;
  logic        resp_ready;

  logic        rv_a  [3];
  logic        rr_a  [3];
  logic        err_a [3];
  logic [63:0] rd_a  [3];

  logic        cur_resp_valid;
  logic        cur_req_ready;
  logic        cur_err;
  logic [63:0] cur_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int W = (g == 0) ? 2 : ((g == 1) ? 0 : 15);
    localparam logic [1:0] ID = 2'(g);
    datamem_responder_if bus ();
    assign bus.req_valid     = req_valid && (sel == ID);
    assign bus.req_write     = req_write;
    assign bus.req_addr      = req_addr;
    assign bus.req_wdata     = req_wdata;
    assign bus.req_xfer_size = req_size;
    assign bus.resp_ready    = resp_ready && (sel == ID);
    assign rv_a[g]  = bus.resp_valid;
    assign rr_a[g]  = bus.req_ready;
    assign err_a[g] = bus.resp_err;
    assign rd_a[g]  = bus.resp_rdata;
    datamem_responder #(.DEPTH_BYTES(64), .WAIT_CYCLES(W)) u_dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.slave)
    );
  end

  assign cur_resp_valid = rv_a[sel];
  assign cur_req_ready  = rr_a[sel];
  assign cur_err        = err_a[sel];
  assign cur_rdata      = rd_a[sel];

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Presents a request and returns at the negedge after the accepting edge.
  task automatic startReq(input logic wr, input logic [63:0] addr, input logic [63:0] wdata,
                          input logic [3:0] size, output logic ok);
    int n;
    @(negedge clk);
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_size  = size;
    req_valid = 1'b1;
    n = 0;
    while (!cur_req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = cur_req_ready;
    if (!ok) begin
      checkOutput("accept_timeout", 64'(cur_req_ready), 64'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic wr, input logic [63:0] addr, input logic [63:0] wdata,
                               input logic [3:0] size, output logic [63:0] rdata,
                               output logic err, output int lat);
    logic ok;
    rdata = '0;
    err   = 1'b1;
    lat   = -1;
    startReq(wr, addr, wdata, size, ok);
    if (!ok) return;
    lat = 1;
    while (!cur_resp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!cur_resp_valid) begin
      checkOutput("resp_timeout", 64'(cur_resp_valid), 64'd1);
      return;
    end
    rdata      = cur_rdata;
    err        = cur_err;
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic doTxn(input string tag, input logic wr, input logic [63:0] addr,
                       input logic [63:0] wdata, input logic [3:0] size,
                       input logic [63:0] exp_rdata, input logic exp_err, input int exp_lat);
    logic [63:0] rdata;
    logic        err;
    int          lat;
    applyStimulus(wr, addr, wdata, size, rdata, err, lat);
    checkOutput({tag, ".rdata"}, rdata, exp_rdata);
    checkOutput({tag, ".err"}, 64'(err), 64'(exp_err));
    if (exp_lat > 0) checkOutput({tag, ".lat"}, 64'(lat), 64'(exp_lat));
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic ok;
    int   n;
    reset      = 1'b0;
    sel        = 2'd0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_size   = 4'd0;
    resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst.req_ready", 64'(cur_req_ready), 64'd0);
    checkOutput("rst.resp_valid", 64'(cur_resp_valid), 64'd0);
    checkOutput("rst.rdata", cur_rdata, 64'd0);
    checkOutput("rst.err", 64'(cur_err), 64'd0);
    reset = 1'b1;

    // Reset aborts a store in WAIT and a pending response, and clears memory.
    doTxn("pre_st", 1'b1, 64'h8, 64'hAAAA_BBBB_CCCC_DDDD, 4'd8, 64'd0, 1'b0, 3);
    startReq(1'b1, 64'h8, 64'h5555_5555_5555_5555, 4'd8, ok);
    reset = 1'b0;
    #1;
    checkOutput("rst_wait.resp_valid", 64'(cur_resp_valid), 64'd0);
    checkOutput("rst_wait.req_ready", 64'(cur_req_ready), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    startReq(1'b0, 64'h8, 64'd0, 4'd8, ok);
    n = 0;
    while (!cur_resp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rst_resp.reached", 64'(cur_resp_valid), 64'd1);
    reset = 1'b0;
    #1;
    checkOutput("rst_resp.resp_valid", 64'(cur_resp_valid), 64'd0);
    checkOutput("rst_resp.rdata", cur_rdata, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    doTxn("post_rst_ld", 1'b0, 64'h8, 64'd0, 4'd8, 64'd0, 1'b0, 3);

    doTxn("st8", 1'b1, 64'h10, 64'h1122_3344_5566_7788, 4'd8, 64'd0, 1'b0, 3);
    doTxn("ld8", 1'b0, 64'h10, 64'd0, 4'd8, 64'h1122_3344_5566_7788, 1'b0, 3);
    doTxn("ld1", 1'b0, 64'h13, 64'd0, 4'd1, 64'h55, 1'b0, 3);
    doTxn("st2", 1'b1, 64'h12, 64'hFFFF_FFFF_FFFF_ABCD, 4'd2, 64'd0, 1'b0, 3);
    doTxn("ld8_part", 1'b0, 64'h10, 64'd0, 4'd8, 64'h1122_3344_ABCD_7788, 1'b0, 3);

    doTxn("err_misalign", 1'b0, 64'h2, 64'd0, 4'd4, 64'd0, 1'b1, 3);
    doTxn("err_range", 1'b1, 64'h40, 64'hDEAD_BEEF_DEAD_BEEF, 4'd8, 64'd0, 1'b1, 3);
    doTxn("err_size3", 1'b1, 64'h10, 64'hDEAD_BEEF_DEAD_BEEF, 4'd3, 64'd0, 1'b1, 3);
    doTxn("err_wrap", 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'hDEAD_BEEF_DEAD_BEEF, 4'd8, 64'd0, 1'b1, 3);
    doTxn("err_chk10", 1'b0, 64'h10, 64'd0, 4'd8, 64'h1122_3344_ABCD_7788, 1'b0, 3);
    doTxn("err_chk00", 1'b0, 64'h0, 64'd0, 4'd8, 64'd0, 1'b0, 3);
    doTxn("err_chk38", 1'b0, 64'h38, 64'd0, 4'd8, 64'd0, 1'b0, 3);
    doTxn("top_st", 1'b1, 64'h38, 64'h0102_0304_0506_0708, 4'd8, 64'd0, 1'b0, 3);
    doTxn("top_ld4", 1'b0, 64'h3C, 64'd0, 4'd4, 64'h0102_0304, 1'b0, 3);

    // Backpressure: response held while a competing store is offered.
    startReq(1'b0, 64'h10, 64'd0, 4'd8, ok);
    n = 0;
    while (!cur_resp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("bp.reached", 64'(cur_resp_valid), 64'd1);
    req_write = 1'b1;
    req_addr  = 64'h0;
    req_wdata = 64'h9999_9999_9999_9999;
    req_size  = 4'd8;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp.resp_valid", 64'(cur_resp_valid), 64'd1);
      checkOutput("bp.rdata", cur_rdata, 64'h1122_3344_ABCD_7788);
      checkOutput("bp.req_ready", 64'(cur_req_ready), 64'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    checkOutput("bp.rel_resp_valid", 64'(cur_resp_valid), 64'd0);
    checkOutput("bp.rel_req_ready", 64'(cur_req_ready), 64'd1);
    doTxn("bp.no_store", 1'b0, 64'h0, 64'd0, 4'd8, 64'd0, 1'b0, 3);

    sel = 2'd1;
    doTxn("w0.st8", 1'b1, 64'h10, 64'h1122_3344_5566_7788, 4'd8, 64'd0, 1'b0, 1);
    doTxn("w0.ld8", 1'b0, 64'h10, 64'd0, 4'd8, 64'h1122_3344_5566_7788, 1'b0, 1);
    sel = 2'd2;
    doTxn("w15.st8", 1'b1, 64'h10, 64'h1122_3344_5566_7788, 4'd8, 64'd0, 1'b0, 16);
    doTxn("w15.ld8", 1'b0, 64'h10, 64'd0, 4'd8, 64'h1122_3344_5566_7788, 1'b0, 16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
